// File: rtl/controle_calc.sv
// Control FSM for a 4-bit keypad calculator: sequences operand loads into X/Y,
// latches the ALU opcode, triggers the result load into Z and times out the display.
`timescale 1ns/1ps

module controle_calc #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] entrada,
   input  logic       digito_valido,
   input  logic [1:0] op,
   input  logic       op_valido,
   input  logic       igual,
   input  logic       limpar,
   output logic [3:0] dado,
   output logic [1:0] sel_x,
   output logic [1:0] sel_y,
   output logic [1:0] sel_z,
   output logic [1:0] op_ula,
   output logic       pronto,
   output logic [3:0] estado
);

   typedef enum logic [3:0] {
      StInicio      = 4'd0,
      StEsperaA     = 4'd1,
      StCarregaA    = 4'd2,
      StEsperaOp    = 4'd3,
      StEsperaB     = 4'd4,
      StCarregaB    = 4'd5,
      StEsperaIgual = 4'd6,
      StCalcula     = 4'd7,
      StMostra      = 4'd8
   } state_e;

   localparam logic [1:0] SelClr  = 2'b00;
   localparam logic [1:0] SelLoad = 2'b01;
   localparam logic [1:0] SelHold = 2'b10;

   localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic       load_dado, load_op;

   // Register commands {sel_x, sel_y, sel_z} for a given state.
   function automatic logic [5:0] sel_decode(input state_e st);
      case (st)
         StInicio:   sel_decode = {SelClr,  SelClr,  SelClr};
         StCarregaA: sel_decode = {SelLoad, SelHold, SelHold};
         StCarregaB: sel_decode = {SelHold, SelLoad, SelHold};
         StCalcula:  sel_decode = {SelHold, SelHold, SelLoad};
         default:    sel_decode = {SelHold, SelHold, SelHold};
      endcase
   endfunction

   // Strobe priority is limpar > digito_valido > op_valido > igual.
   always_comb begin
      state_d   = state_q;
      load_dado = 1'b0;
      load_op   = 1'b0;
      if (limpar) begin
         state_d = StInicio;
      end else begin
         case (state_q)
            StInicio:   state_d = StEsperaA;
            StEsperaA: begin
               if (digito_valido) begin
                  state_d   = StCarregaA;
                  load_dado = 1'b1;
               end
            end
            StCarregaA: state_d = StEsperaOp;
            StEsperaOp: begin
               if (digito_valido) begin
                  state_d   = StCarregaA;
                  load_dado = 1'b1;
               end else if (op_valido) begin
                  state_d = StEsperaB;
                  load_op = 1'b1;
               end
            end
            StEsperaB: begin
               if (digito_valido) begin
                  state_d   = StCarregaB;
                  load_dado = 1'b1;
               end else if (op_valido) begin
                  load_op = 1'b1;
               end
            end
            StCarregaB: state_d = StEsperaIgual;
            StEsperaIgual: begin
               if (digito_valido) begin
                  state_d   = StCarregaB;
                  load_dado = 1'b1;
               end else if (op_valido) begin
                  load_op = 1'b1;
               end else if (igual) begin
                  state_d = StCalcula;
               end
            end
            StCalcula:  state_d = StMostra;
            StMostra: begin
               if (digito_valido) begin
                  state_d   = StCarregaA;
                  load_dado = 1'b1;
               end else if (timer_q == TimerLast) begin
                  state_d = StInicio;
               end
            end
            default:    state_d = StInicio;
         endcase
      end
   end

   // Timer restarts at zero on every entry into MOSTRA.
   always_comb begin
      timer_d = 8'd0;
      if (state_q == StMostra && state_d == StMostra) begin
         timer_d = timer_q + 8'd1;
      end
   end

   // Outputs are registered from the next state so they track the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInicio;
         timer_q <= 8'd0;
         dado    <= 4'd0;
         op_ula  <= 2'd0;
         pronto  <= 1'b0;
         sel_x   <= SelClr;
         sel_y   <= SelClr;
         sel_z   <= SelClr;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (load_dado) begin
            dado <= entrada;
         end
         if (load_op) begin
            op_ula <= op;
         end
         pronto                <= (state_d == StMostra);
         {sel_x, sel_y, sel_z} <= sel_decode(state_d);
      end
   end

   assign estado = state_q;

endmodule

// File: tb/tb_controle_calc.sv
// Randomized scoreboard bench for controle_calc against a step-level reference model.
`timescale 1ns/1ps

module tb_controle_calc;

   localparam int unsigned T = 4;

   // State numbering from the requirements.
   localparam int INICIO = 0, ESPERA_A = 1, CARREGA_A = 2, ESPERA_OP = 3, ESPERA_B = 4;
   localparam int CARREGA_B = 5, ESPERA_IGUAL = 6, CALCULA = 7, MOSTRA = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] entrada = 4'd0;
   logic       digito_valido = 1'b0;
   logic [1:0] op = 2'd0;
   logic       op_valido = 1'b0;
   logic       igual = 1'b0;
   logic       limpar = 1'b0;
   logic [3:0] dado;
   logic [1:0] sel_x, sel_y, sel_z, op_ula;
   logic       pronto;
   logic [3:0] estado;

   always #5 clk = ~clk;

   controle_calc #(.TIMEOUT(T)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .entrada       (entrada),
      .digito_valido (digito_valido),
      .op            (op),
      .op_valido     (op_valido),
      .igual         (igual),
      .limpar        (limpar),
      .dado          (dado),
      .sel_x         (sel_x),
      .sel_y         (sel_y),
      .sel_z         (sel_z),
      .op_ula        (op_ula),
      .pronto        (pronto),
      .estado        (estado)
   );

   typedef struct packed {
      logic [3:0] estado;
      logic [1:0] sx;
      logic [1:0] sy;
      logic [1:0] sz;
      logic [3:0] dado;
      logic [1:0] op_ula;
      logic       pronto;
   } obs_t;

   obs_t expq[$];
   obs_t e_obs, a_obs;
   int   total = 0, bad = 0, pushes = 0, pops = 0;
   bit   mon_on = 1'b1;

   // Reference model: operand/opcode/display progress of one calculation.
   int         ms = INICIO;
   logic [3:0] m_dado = 4'd0;
   logic [1:0] m_op = 2'd0;
   int         m_shown = 0;

   function automatic obs_t expect_of(input int s, input logic [3:0] d, input logic [1:0] o);
      obs_t r;
      r.estado = 4'(s);
      r.dado   = d;
      r.op_ula = o;
      r.pronto = (s == MOSTRA);
      case (s)
         INICIO:    {r.sx, r.sy, r.sz} = 6'b00_00_00;
         CARREGA_A: {r.sx, r.sy, r.sz} = 6'b01_10_10;
         CARREGA_B: {r.sx, r.sy, r.sz} = 6'b10_01_10;
         CALCULA:   {r.sx, r.sy, r.sz} = 6'b10_10_01;
         default:   {r.sx, r.sy, r.sz} = 6'b10_10_10;
      endcase
      return r;
   endfunction

   task automatic model_step(input logic l, input logic d, input logic [3:0] e,
                             input logic o, input logic [1:0] opv, input logic i);
      int nxt;
      nxt = ms;
      if (l) nxt = INICIO;
      else if (d && ms != INICIO && ms != CARREGA_A && ms != CARREGA_B && ms != CALCULA) begin
         // Any digit accepted: second operand when an opcode is pending, else first.
         nxt    = (ms == ESPERA_B || ms == ESPERA_IGUAL) ? CARREGA_B : CARREGA_A;
         m_dado = e;
      end else if (ms == INICIO) nxt = ESPERA_A;
      else if (ms == CARREGA_A) nxt = ESPERA_OP;
      else if (ms == CARREGA_B) nxt = ESPERA_IGUAL;
      else if (ms == CALCULA) nxt = MOSTRA;
      else if (o && (ms == ESPERA_OP || ms == ESPERA_B || ms == ESPERA_IGUAL)) begin
         m_op = opv;
         if (ms == ESPERA_OP) nxt = ESPERA_B;
      end else if (i && ms == ESPERA_IGUAL) nxt = CALCULA;
      else if (ms == MOSTRA && m_shown == int'(T)) nxt = INICIO;
      // Number of cycles the result has been displayed so far.
      m_shown = (nxt == MOSTRA) ? ((ms == MOSTRA) ? m_shown + 1 : 1) : 0;
      ms = nxt;
   endtask

   // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
   task automatic step(input logic rst, input logic l, input logic d, input logic [3:0] e,
                       input logic o, input logic [1:0] opv, input logic i);
      @(negedge clk);
      #1;
      rst_n         = ~rst;
      limpar        = l;
      digito_valido = d;
      entrada       = e;
      op_valido     = o;
      op            = opv;
      igual         = i;
      if (rst) begin
         ms = INICIO; m_dado = 4'd0; m_op = 2'd0; m_shown = 0;
      end else begin
         model_step(l, d, e, o, opv, i);
      end
      expq.push_back(expect_of(ms, m_dado, m_op));
      pushes++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Monitor: every falling edge the DUT presents a fresh output set.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on && expq.size() > 0) begin
            e_obs = expq.pop_front();
            pops++;
            a_obs = {estado, sel_x, sel_y, sel_z, dado, op_ula, pronto};
            total++;
            if (a_obs !== e_obs) begin
               bad++;
               $display("FAIL cycle t=%0t got st=%0d sel=%b/%b/%b dado=%h op=%b pr=%b exp st=%0d sel=%b/%b/%b dado=%h op=%b pr=%b",
                        $time, a_obs.estado, a_obs.sx, a_obs.sy, a_obs.sz, a_obs.dado,
                        a_obs.op_ula, a_obs.pronto, e_obs.estado, e_obs.sx, e_obs.sy,
                        e_obs.sz, e_obs.dado, e_obs.op_ula, e_obs.pronto);
            end
         end
      end
   end

   initial begin
      int r;
      step(1'b1, 0, 0, 4'd0, 0, 2'd0, 0);
      step(1'b1, 0, 0, 4'd0, 0, 2'd0, 0);
      idle(2);
      // Full sequence: 3, op 01, 5, equals, then timeout.
      step(0, 0, 1, 4'd3, 0, 2'd0, 0);
      idle(1);
      step(0, 0, 0, 4'd0, 1, 2'd1, 0);
      step(0, 0, 1, 4'd5, 0, 2'd0, 0);
      idle(1);
      step(0, 0, 0, 4'd0, 0, 2'd0, 1);
      idle(8);
      // Operand replacement.
      step(0, 0, 1, 4'd2, 0, 2'd0, 0);
      idle(2);
      step(0, 0, 1, 4'd7, 0, 2'd0, 0);
      idle(2);
      // Simultaneous strobes.
      step(0, 0, 0, 4'd0, 1, 2'd2, 0);
      step(0, 1, 1, 4'd9, 0, 2'd0, 0);
      idle(2);
      step(0, 0, 1, 4'd1, 0, 2'd0, 0);
      idle(1);
      step(0, 0, 1, 4'd4, 1, 2'd3, 0);
      idle(2);
      // Digit on the last display cycle beats the timeout.
      step(0, 0, 0, 4'd0, 1, 2'd1, 0);
      step(0, 0, 1, 4'd6, 0, 2'd0, 0);
      idle(1);
      step(0, 0, 0, 4'd0, 0, 2'd0, 1);
      idle(4);
      step(0, 0, 1, 4'hc, 0, 2'd0, 0);
      idle(3);
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 999);
         step(r < 5, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25, 4'($urandom),
              $urandom_range(0, 99) < 20, 2'($urandom), $urandom_range(0, 99) < 25);
      end
      idle(1);
      for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
      mon_on = 1'b0;
      chk("scoreboard_drain", 32'(pops), 32'(pushes));

      // Asynchronous reset in the middle of a CARREGA_A cycle.
      @(negedge clk);
      #1;
      rst_n = 1'b0; limpar = 0; digito_valido = 0; op_valido = 0; igual = 0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_reset_espera_a", 32'(estado), 32'(ESPERA_A));
      digito_valido = 1'b1;
      entrada       = 4'ha;
      @(posedge clk);
      #1;
      digito_valido = 1'b0;
      chk("carrega_a_sel_x", 32'(sel_x), 32'b01);
      chk("carrega_a_dado", 32'(dado), 32'ha);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_estado", 32'(estado), 32'd0);
      chk("async_sel", 32'({sel_x, sel_y, sel_z}), 32'd0);
      chk("async_dado", 32'(dado), 32'd0);
      chk("async_pronto", 32'(pronto), 32'd0);
      @(posedge clk);
      #1;
      chk("held_reset_estado", 32'(estado), 32'd0);
      chk("held_reset_sel_x", 32'(sel_x), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controle_calc.md
CONTROLE_CALC -- requirements
Module: controle_calc

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of cycles MOSTRA is held before automatic clear; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 entrada  input  4  digit value presented by the keypad decoder.
REQ-005 digito_valido  input  1  one-cycle strobe; entrada is valid in the same cycle.
REQ-006 op  input  2  operation code; valid when op_valido=1.
REQ-007 op_valido  input  1  one-cycle strobe for op.
REQ-008 igual  input  1  one-cycle "equals" strobe.
REQ-009 limpar  input  1  one-cycle clear strobe.
REQ-010 dado  output  4  registered digit driving the entrada port of registers X and Y.
REQ-011 sel_x, sel_y, sel_z  output  2 each  register commands: 00 clear, 01 load, 10 hold; 11 is never driven.
REQ-012 op_ula  output  2  registered operation code to the ALU.
REQ-013 pronto  output  1  high while a result is displayed (state MOSTRA).
REQ-014 estado  output  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM with states INICIO=0, ESPERA_A=1, CARREGA_A=2, ESPERA_OP=3, ESPERA_B=4, CARREGA_B=5, ESPERA_IGUAL=6, CALCULA=7, MOSTRA=8.
REQ-016 sel_x/sel_y/sel_z SHALL be decoded from the current state only:
- INICIO: 00/00/00.
- CARREGA_A: 01/10/10.
- CARREGA_B: 10/01/10.
- CALCULA: 10/10/01.
- All other states: 10/10/10.
REQ-017 Strobe priority within one cycle SHALL be limpar > digito_valido > op_valido > igual; a lower-priority strobe in the same cycle is discarded.
REQ-018 limpar=1 in any state SHALL force the next state to INICIO.
REQ-019 INICIO SHALL go to ESPERA_A after one cycle.
REQ-020 ESPERA_A: digito_valido -> CARREGA_A; op_valido and igual are ignored.
REQ-021 CARREGA_A SHALL last exactly one cycle, then go to ESPERA_OP.
REQ-022 ESPERA_OP:
- digito_valido -> CARREGA_A (operand A is replaced).
- op_valido -> ESPERA_B with op_ula<=op.
- igual is ignored.
REQ-023 ESPERA_B: digito_valido -> CARREGA_B; op_valido updates op_ula and stays in ESPERA_B; igual is ignored.
REQ-024 CARREGA_B SHALL last exactly one cycle, then go to ESPERA_IGUAL.
REQ-025 ESPERA_IGUAL:
- digito_valido -> CARREGA_B (operand B is replaced).
- op_valido updates op_ula and stays.
- igual -> CALCULA.
REQ-026 CALCULA SHALL last exactly one cycle, then go to MOSTRA.
REQ-027 MOSTRA:
- pronto=1.
- digito_valido -> CARREGA_A (a new calculation starts; Y and Z are not cleared).
- op_valido and igual are ignored.
- Otherwise the state is held until the timeout (REQ-029).
REQ-028 dado SHALL load entrada on every accepted digito_valido (any transition into CARREGA_A or CARREGA_B) and SHALL hold otherwise; latency from strobe to the load command is 1 cycle.
REQ-029 An 8-bit timer SHALL be zero on entry to MOSTRA and increment each cycle in MOSTRA; when the timer equals TIMEOUT-1 with no strobe present, the next state SHALL be INICIO.
REQ-030 A strobe arriving in the same cycle as the timeout SHALL take precedence over the timeout.
REQ-031 op_ula SHALL change only on an accepted op_valido, or on reset.

Reset
REQ-032 While rst_n=0, independent of clk:
- state=INICIO.
- dado=0000, op_ula=00, timer=0.
- pronto=0.
- sel_x=sel_y=sel_z=00.
REQ-033 Reset deassertion SHALL be followed by one INICIO cycle before ESPERA_A.
REQ-034 Reset asserted mid-sequence (e.g. in CARREGA_B) SHALL abort the sequence immediately, with no further load command issued.

Verification
REQ-035 Full sequence:
- Stimulus: digit 3; op=01; digit 5; igual.
- Required: sel_x=01 one cycle after the first strobe with dado=0011; op_ula=01; sel_y=01 with dado=0101; sel_z=01 one cycle after igual; then pronto=1.
REQ-036 Operand replacement:
- Stimulus: digit 2, then digit 7 while in ESPERA_OP.
- Required: a second CARREGA_A cycle with dado=0111; state returns to ESPERA_OP.
REQ-037 Simultaneous strobes:
- limpar+digito_valido in ESPERA_B -> INICIO, with dado unchanged.
- digito_valido+op_valido in ESPERA_OP -> CARREGA_A, with op_ula unchanged.
REQ-038 Timeout:
- Stimulus: TIMEOUT=4; reach MOSTRA; no strobes.
- Required: pronto=1 for exactly 4 cycles, then INICIO with all sel=00.
REQ-039 Asynchronous reset:
- Stimulus: drop rst_n mid-cycle while in CARREGA_A.
- Required: outputs reach reset values before the next clk edge; sel_x never shows 11.
